// File: rtl/rep_add_mul_pkg.sv
// Shared types and constants for the repeated-addition multiplier.
package rep_add_mul_pkg;

    localparam int DEF_WIDTH = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        CALC   = 3'd3,
        DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/rep_add_datapath.sv
// A/B/P registers with accumulate adder, B down-counter and zero detect.
module rep_add_datapath
    import rep_add_mul_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             ld_a,
    input  logic             ld_b,
    input  logic             ld_p,
    input  logic             clr_p,
    input  logic             dec_b,
    output logic             eqz,
    output logic [WIDTH-1:0] p
);

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a <= '0;
            b <= '0;
            p <= '0;
        end else begin
            if (ld_a)
                a <= data_in;
            if (ld_b)
                b <= data_in;
            else if (dec_b)
                b <= b - 1'b1;
            // Sum wraps at WIDTH bits; the carry is intentionally dropped.
            if (clr_p)
                p <= '0;
            else if (ld_p)
                p <= p + a;
        end
    end

    assign eqz = (b == '0);

endmodule

// File: rtl/rep_add_multiplier.sv
// Sequential unsigned multiplier: product = A added B times, host-driven via start/done.
module rep_add_multiplier
    import rep_add_mul_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] product,
    output logic             done,
    output logic             busy
);

    state_t state;
    logic   eqz;
    logic   ld_a, ld_b, ld_p, clr_p, dec_b;

    assign ld_a  = (state == LOAD_A);
    assign ld_b  = (state == LOAD_B);
    assign clr_p = (state == LOAD_B);
    assign ld_p  = (state == CALC) && !eqz;
    assign dec_b = (state == CALC) && !eqz;

    // done/busy are updated together with state so they track it exactly.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            done  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state <= LOAD_A;
                    busy  <= 1'b1;
                end
                LOAD_A: state <= LOAD_B;
                LOAD_B: state <= CALC;
                CALC: if (eqz) begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                DONE: if (!start) begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    rep_add_datapath #(.WIDTH(WIDTH)) u_dp (
        .clk     (clk),
        .rst_n   (rst_n),
        .data_in (data_in),
        .ld_a    (ld_a),
        .ld_b    (ld_b),
        .ld_p    (ld_p),
        .clr_p   (clr_p),
        .dec_b   (dec_b),
        .eqz     (eqz),
        .p       (product)
    );

endmodule

// File: tb/tb_rep_add_multiplier.sv
// Scoreboard bench: stimulus pushes expected results, a monitor checks each done rising edge.
module tb_rep_add_multiplier;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] data_in = '0;
    logic [W-1:0] product;
    logic         done;
    logic         busy;

    typedef struct {
        logic [W-1:0] p;
        int           c0;
        int           b;
        string        name;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_pass = 0;
    int   n_tot = 0;
    logic prev_done = 1'b0;

    rep_add_multiplier #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .data_in (data_in),
        .product (product),
        .done    (done),
        .busy    (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input longint act, input longint exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Monitor: every rising edge of done consumes one expected result.
    always @(negedge clk) begin
        if (done && !prev_done) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk({e.name, "_product"}, product, e.p);
                chk({e.name, "_latency"}, cyc - e.c0, e.b + 3);
                chk({e.name, "_busy_in_done"}, busy, 0);
            end
        end
        prev_done = done;
    end

    // Drives start then A then B; leaves the bench at the negedge after B is captured.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] p, input string name, input bit push);
        exp_t e;
        @(negedge clk); start = 1'b1; data_in = a;
        @(negedge clk); start = 1'b0;
        e.p = p; e.c0 = cyc; e.b = int'(b); e.name = name;
        if (push) q.push_back(e);
        @(negedge clk); data_in = b;
        @(negedge clk); data_in = 16'h5A5A;
    endtask

    task automatic wait_done(input string name, input int bound);
        int n = 0;
        while (!done && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (!done) chk({name, "_timeout"}, 0, 1);
    endtask

    task automatic run(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] p, input string name);
        issue(a, b, p, name, 1'b1);
        wait_done(name, int'(b) + 10);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_product", product, 0);
        chk("reset_done", done, 0);
        chk("reset_busy", busy, 0);
        rst_n = 1'b1;

        // start never asserted: data_in wiggles must not disturb anything
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); data_in = 16'(i * 16'h1357 + 1);
            if (product != 0 || done || busy) chk("idle_stable", {product, done, busy}, 0);
        end
        chk("idle_product", product, 0);
        chk("idle_busy", busy, 0);

        issue(17, 5, 85, "basic", 1'b1);
        chk("basic_busy_calc", busy, 1);
        wait_done("basic", 15);

        // start held in DONE must not retrigger
        start = 1'b1;
        for (int i = 0; i < 4; i++) @(negedge clk);
        chk("hold_done", done, 1);
        chk("hold_product", product, 85);
        chk("hold_busy", busy, 0);
        start = 1'b0;
        @(negedge clk);
        chk("to_idle_done", done, 0);
        chk("to_idle_busy", busy, 0);
        chk("idle_retain", product, 85);

        run(3, 4, 12, "restart");
        @(negedge clk);
        run(9, 0, 0, "zero_b");
        @(negedge clk);
        run(0, 3, 0, "zero_a");
        @(negedge clk);
        run(16'hFFFF, 2, 16'hFFFE, "overflow");
        chk("overflow_done", done, 1);
        @(negedge clk);
        run(16'd300, 16'd250, 16'(300 * 250), "wide");
        @(negedge clk);

        // reset in the middle of CALC aborts the run
        issue(10, 7, 70, "abort", 1'b0);
        @(negedge clk); @(negedge clk);
        chk("abort_busy_before", busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_product", product, 0);
        chk("abort_done", done, 0);
        chk("abort_busy", busy, 0);
        run(2, 6, 12, "after_abort");
        @(negedge clk); @(negedge clk);

        chk("scoreboard_empty", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/rep_add_multiplier.md
Name: rep_add_multiplier

Overview:
- Unsigned sequential multiplier using repeated addition: P = A added B times.
- Operands A and B arrive one after the other on a single shared data_in bus.
- Internally a datapath (A, B, P registers, adder, decrementer, zero detect) driven by a small FSM controller.
- Standalone arithmetic block that a host sequences with start/done.

Parameters:
- WIDTH, 16, width of data_in, the A/B/P registers and product.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset; synchronous and active-low.
- start  in  1  request; sampled in IDLE and DONE.
- data_in  in  WIDTH  operand bus: A in LOAD_A, B in LOAD_B.
- product  out  WIDTH  current P register value.
- done  out  1  high while in DONE.
- busy  out  1  high in LOAD_A, LOAD_B and CALC.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - State goes to IDLE; A, B and P go to 0.
  - product=0, done=0, busy=0 from the next cycle.
  - Reset overrides every other condition, including a reset mid-operation, which aborts it with no partial result kept.
- IDLE: no register changes. If start=1, go to LOAD_A.
- LOAD_A: A <= data_in; go to LOAD_B. start is ignored.
- LOAD_B: B <= data_in; P <= 0; go to CALC.
- CALC, with eqz = (B == 0) decoded combinationally from the B register:
  - If eqz=1: go to DONE; A, B and P hold.
  - Else: P <= P + A (truncated to WIDTH bits, carry discarded); B <= B - 1; stay in CALC.
- DONE:
  - done=1; product holds A*B mod 2^WIDTH.
  - If start=0, go to IDLE; else stay in DONE.
  - A start held high therefore does not retrigger; the host must drop start to 0 for at least one cycle before starting again.
- product continuously reflects P:
  - It is cleared in LOAD_B and counts up during CALC.
  - It is valid only while done=1.
  - The last result is retained in IDLE until the next LOAD_B.
- Latency, with start sampled at edge k:
  - A captured at k+1, B captured at k+2.
  - B additions at edges k+3 .. k+B+2.
  - DONE entered at edge k+B+3; done high from then on.
  - Total is B+3 cycles from start sampling to done.
- Boundary cases:
  - B=0: zero additions; DONE after 3 cycles with product=0.
  - A=0: product stays 0, still B+3 cycles.
  - Maximum operands: up to 2^WIDTH+2 cycles; no timeout.
- Controller outputs to datapath, all Moore-decoded from state:
  - ldA in LOAD_A.
  - ldB and clrP in LOAD_B.
  - ldP and decB in CALC when eqz=0.
- Datapath output to controller: eqz.
- No combinational path from data_in to any output.

Decomposition:
- Shared package rep_add_mul_pkg:
  - state enum {IDLE, LOAD_A, LOAD_B, CALC, DONE}, 3-bit encoding.
  - Default WIDTH constant.
- Sub-module rep_add_datapath holds:
  - A, B and P registers.
  - The adder, the B decrementer and the eqz compare.
  - Inputs: ldA, ldB, ldP, clrP, decB.
- FSM (state register plus next-state and output decode) lives in the top module.

Test Plan:
- Basic multiply: reset, start=1, data_in=17 in LOAD_A then 5 in LOAD_B -> product=85, done rises 8 cycles after the start edge (B+3), busy low in DONE.
- Zero B: A=9, B=0 -> done after 3 cycles, product=0. Zero A: A=0, B=3 -> done after 6 cycles, product=0.
- Overflow: WIDTH=16, A=16'hFFFF, B=2 -> product=16'hFFFE, done asserted.
- Restart handshake:
  - Keep start=1 in DONE -> remains in DONE, product stable.
  - Drop start for 1 cycle -> IDLE.
  - Start again with A=3, B=4 -> product=12.
- Reset mid-CALC: A=10, B=7, assert rst_n=0 for one edge during CALC -> next cycle product=0, done=0, busy=0, state IDLE; a new run 2*6 yields 12.
- Start not asserted: hold start=0 and toggle data_in for 20 cycles -> product, done and busy unchanged from reset values.
